// File: rtl/arm7tdmi_multiply.sv
// ARM7TDMI multiply / multiply-accumulate datapath (MUL, MLA, xMULL, xMLAL) with held writeback copy.
// Optional define ARM7TDMI_MUL_CYCLES_EN adds the early-termination cycle count output mul_cycles.
module arm7tdmi_multiply (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mul_en,
  input  logic        mul_long,
  input  logic        mul_signed,
  input  logic        mul_accumulate,
  input  logic        mul_set_flags,
  input  logic [1:0]  mul_type,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo,
  output logic        result_ready,
  output logic        negative,
  output logic        zero
`ifdef ARM7TDMI_MUL_CYCLES_EN
  ,
  output logic [2:0]  mul_cycles
`endif
);

  logic        is_long;
  logic        is_acc;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] acc_ext;
  logic [63:0] sum;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;
  logic        flag_n;
  logic        flag_z;

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        n_q, n_d;
  logic        z_q, z_d;

  // Sign extension only matters for long ops; the low word is sign-agnostic.
  always_comb begin
    is_long = mul_type[1] | mul_long;
    is_acc  = mul_type[0] | mul_accumulate;
    a_ext   = (is_long && mul_signed) ? {{32{operand_a[31]}}, operand_a} : {32'h0, operand_a};
    b_ext   = (is_long && mul_signed) ? {{32{operand_b[31]}}, operand_b} : {32'h0, operand_b};
    acc_ext = '0;
    if (is_acc) begin
      acc_ext = is_long ? {acc_hi, acc_lo} : {32'h0, acc_lo};
    end
    sum     = (a_ext * b_ext) + acc_ext;
    prod_lo = sum[31:0];
    prod_hi = is_long ? sum[63:32] : '0;
    flag_n  = is_long ? sum[63] : sum[31];
    flag_z  = is_long ? (sum == 64'h0) : (sum[31:0] == 32'h0);
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    n_d  = n_q;
    z_d  = z_q;
    if (mul_en) begin
      hi_d = prod_hi;
      lo_d = prod_lo;
      if (mul_set_flags) begin
        n_d = flag_n;
        z_d = flag_z;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
      n_q  <= 1'b0;
      z_q  <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      n_q  <= n_d;
      z_q  <= z_d;
    end
  end

  always_comb begin
    result_ready = mul_en;
    result_hi    = mul_en ? prod_hi : hi_q;
    result_lo    = mul_en ? prod_lo : lo_q;
    negative     = (mul_en && mul_set_flags) ? flag_n : n_q;
    zero         = (mul_en && mul_set_flags) ? flag_z : z_q;
  end

`ifdef ARM7TDMI_MUL_CYCLES_EN
  logic       ones_ok;
  logic [2:0] m_base;

  // All-ones early termination is not available for unsigned long multiplies.
  always_comb begin
    mul_cycles = '0;
    ones_ok    = !(is_long && !mul_signed);
    if ((operand_b[31:8] == '0) || (ones_ok && (operand_b[31:8] == '1))) begin
      m_base = 3'd1;
    end else if ((operand_b[31:16] == '0) || (ones_ok && (operand_b[31:16] == '1))) begin
      m_base = 3'd2;
    end else if ((operand_b[31:24] == '0) || (ones_ok && (operand_b[31:24] == '1))) begin
      m_base = 3'd3;
    end else begin
      m_base = 3'd4;
    end
    if (mul_en) begin
      mul_cycles = m_base + {2'b00, is_long} + {2'b00, is_acc};
    end
  end
`endif

endmodule

// File: tb/tb_arm7tdmi_multiply.sv
// Self-checking bench for arm7tdmi_multiply: directed test-plan steps followed by randomized ops vs. an arithmetic model.
module tb_arm7tdmi_multiply;

  logic        clk;
  logic        rst_n;
  logic        mul_en;
  logic        mul_long;
  logic        mul_signed;
  logic        mul_accumulate;
  logic        mul_set_flags;
  logic [1:0]  mul_type;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] result_hi;
  logic [31:0] result_lo;
  logic        result_ready;
  logic        negative;
  logic        zero;
`ifdef ARM7TDMI_MUL_CYCLES_EN
  logic [2:0]  mul_cycles;
`endif

  int unsigned tests;
  int unsigned fails;

  logic [31:0] h_hi, h_lo;
  logic        h_n, h_z;

  arm7tdmi_multiply dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mul_en         (mul_en),
    .mul_long       (mul_long),
    .mul_signed     (mul_signed),
    .mul_accumulate (mul_accumulate),
    .mul_set_flags  (mul_set_flags),
    .mul_type       (mul_type),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .acc_hi         (acc_hi),
    .acc_lo         (acc_lo),
    .result_hi      (result_hi),
    .result_lo      (result_lo),
    .result_ready   (result_ready),
    .negative       (negative),
    .zero           (zero)
`ifdef ARM7TDMI_MUL_CYCLES_EN
    ,
    .mul_cycles     (mul_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic en, input logic lng, input logic sgn, input logic acc,
                       input logic sf, input logic [1:0] typ, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ahi, input logic [31:0] alo);
    @(negedge clk);
    mul_en = en; mul_long = lng; mul_signed = sgn; mul_accumulate = acc;
    mul_set_flags = sf; mul_type = typ; operand_a = a; operand_b = b;
    acc_hi = ahi; acc_lo = alo;
    #1;
  endtask

  // Arithmetic reference: full-precision product then truncation.
  task automatic model(output logic [31:0] hi, output logic [31:0] lo, output logic n, output logic z);
    longint unsigned p;
    logic [31:0]     s;
    if (mul_type[1] || mul_long) begin
      if (mul_signed) p = longint'($signed(operand_a)) * longint'($signed(operand_b));
      else            p = longint'({32'h0, operand_a}) * longint'({32'h0, operand_b});
      if (mul_type[0] || mul_accumulate) p = p + {acc_hi, acc_lo};
      hi = p[63:32]; lo = p[31:0]; n = p[63]; z = (p == 0);
    end else begin
      s = operand_a * operand_b;
      if (mul_type[0] || mul_accumulate) s = s + acc_lo;
      hi = 32'h0; lo = s; n = s[31]; z = (s == 0);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic er, input logic en, input logic ez);
    tests++;
    assert (result_hi === ehi) else begin fails++; $error("FAIL %s result_hi got %h exp %h", tag, result_hi, ehi); end
    tests++;
    assert (result_lo === elo) else begin fails++; $error("FAIL %s result_lo got %h exp %h", tag, result_lo, elo); end
    tests++;
    assert (result_ready === er) else begin fails++; $error("FAIL %s result_ready got %b exp %b", tag, result_ready, er); end
    tests++;
    assert (negative === en) else begin fails++; $error("FAIL %s negative got %b exp %b", tag, negative, en); end
    tests++;
    assert (zero === ez) else begin fails++; $error("FAIL %s zero got %b exp %b", tag, zero, ez); end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] mhi, mlo;
    logic        mn, mz;
    model(mhi, mlo, mn, mz);
    if (mul_en) check(tag, mhi, mlo, 1'b1, mul_set_flags ? mn : h_n, mul_set_flags ? mz : h_z);
    else        check(tag, h_hi, h_lo, 1'b0, h_n, h_z);
  endtask

  task automatic commit();
    logic [31:0] mhi, mlo;
    logic        mn, mz;
    model(mhi, mlo, mn, mz);
    @(posedge clk);
    #1;
    if (rst_n && mul_en) begin
      h_hi = mhi; h_lo = mlo;
      if (mul_set_flags) begin h_n = mn; h_z = mz; end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    tests = 0; fails = 0;
    h_hi = '0; h_lo = '0; h_n = 1'b0; h_z = 1'b0;
    rst_n = 1'b0;
    mul_en = 0; mul_long = 0; mul_signed = 0; mul_accumulate = 0; mul_set_flags = 0;
    mul_type = 2'b00; operand_a = '0; operand_b = '0; acc_hi = '0; acc_lo = '0;
    #2;
    check("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1, 0, 0, 0, 1, 2'b00, 32'd5, 32'd7, 32'h0, 32'h0);
    check("mul5x7", 32'h0, 32'd35, 1'b1, 1'b0, 1'b0); commit();
    drive(1, 0, 0, 0, 0, 2'b01, 32'd3, 32'd4, 32'h0, 32'd2);
    check("mla", 32'h0, 32'd14, 1'b1, 1'b0, 1'b0); commit();
    drive(1, 0, 0, 0, 1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    check("umull", 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b1, 1'b0); commit();
    drive(1, 0, 1, 0, 1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    check("smull", 32'h0, 32'h1, 1'b1, 1'b0, 1'b0); commit();
    drive(1, 0, 1, 0, 1, 2'b11, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'd5);
    check("smlal", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0); commit();
    drive(1, 0, 0, 0, 1, 2'b00, 32'd0, 32'd42, 32'h0, 32'h0);
    check("mul0", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1); commit();
    drive(0, 0, 0, 0, 1, 2'b00, 32'd9, 32'd9, 32'h0, 32'h0);
    check("idle_hold", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1); commit();
    drive(1, 1, 0, 1, 1, 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'hFFFF_FFFF);
    check("force_long_acc", 32'h2, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0); commit();
    drive(1, 0, 1, 0, 1, 2'b00, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0);
    check("short_signed_ign", 32'h0, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0); commit();
    drive(1, 0, 0, 0, 1, 2'b10, 32'h0, 32'h1234, 32'h0, 32'h0);
    check("long_zero", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1); commit();

    drive(1, 0, 0, 0, 1, 2'b00, 32'd6, 32'd7, 32'h0, 32'h0);
    commit();
    drive(0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    check("held42", 32'h0, 32'd42, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    h_hi = '0; h_lo = '0; h_n = 1'b0; h_z = 1'b0;
    check("async_reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1, 0, 0, 0, 0, 2'b00, 32'd3, 32'd3, 32'h0, 32'h0);
    check("comb_in_reset", 32'h0, 32'd9, 1'b1, 1'b0, 1'b0); commit();
    drive(0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    check("reset_held", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 4) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
            pick(), pick(), pick(), pick());
      check_model($sformatf("rand%0d", i));
      commit();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tb did not finish got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/arm7tdmi_multiply.md
# arm7tdmi_multiply

Integer multiply/multiply-accumulate datapath for the ARM7TDMI core, covering MUL, MLA, UMULL, SMULL, UMLAL and SMLAL. The decode/execute stage drives it with register operands and an optional 64-bit accumulator. It returns a 32- or 64-bit product with N/Z flags in the same cycle. It also keeps a registered copy of the last result and flags for the writeback path.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mul_en  in  1  operation request, level-sensitive.
- mul_long  in  1  force 64-bit result (ORed with mul_type[1]).
- mul_signed  in  1  long ops: 1 = signed (SMULL/SMLAL), 0 = unsigned.
- mul_accumulate  in  1  force accumulate (ORed with mul_type[0]).
- mul_set_flags  in  1  S bit: update N/Z.
- mul_type  in  2  00 MUL, 01 MLA, 10 xMULL, 11 xMLAL.
- operand_a  in  32  Rm.
- operand_b  in  32  Rs.
- acc_hi  in  32  accumulator high word (long accumulate only).
- acc_lo  in  32  accumulator low word (MLA Rn / xMLAL RdLo).
- result_hi  out  32  product [63:32]; 0 for short ops.
- result_lo  out  32  product [31:0].
- result_ready  out  1  result valid this cycle.
- negative  out  1  N flag.
- zero  out  1  Z flag.

## Operation
- Effective long L = mul_type[1] | mul_long. Effective accumulate A = mul_type[0] | mul_accumulate.
- Short (L=0): lo = (a*b + (A ? acc_lo : 0)) mod 2^32; hi = 0; mul_signed ignored, since the low word is sign-agnostic.
- Long (L=1): 64-bit product P = a*b. If mul_signed, operands are sign-extended to 64 bits; otherwise they are zero-extended. If A, add {acc_hi,acc_lo} mod 2^64. Result is {hi,lo}.
- Flags, when mul_set_flags=1: N = bit 31 (short) or bit 63 (long). Z = 1 iff lo==0 (short) or {hi,lo}==0 (long). C and V are not produced.
- When mul_set_flags=0, negative/zero present the held flag registers unchanged.
- While mul_en=1, outputs are combinational from the current inputs and result_ready=1.
- While mul_en=0, result_hi/result_lo/negative/zero present the held registers and result_ready=0.
- Held registers: on each rising edge with mul_en=1, result_hi/lo are captured. Flags are captured only if mul_set_flags=1.

## Timing
- Zero-latency combinational result. The value is valid before the rising edge that ends the cycle in which mul_en is high. Consumers sample at that edge.
- Held registers update on that same edge and are visible from the next cycle while mul_en=0.
- Back-to-back operations are allowed every cycle. There is no busy state.
- Reset (async assert, sync to clk deassert by system) clears held result_hi, result_lo, negative and zero to 0.
- Reset value of every output with mul_en=0: result_hi=0, result_lo=0, result_ready=0, negative=0, zero=0.
- Reset mid-operation clears the held registers immediately. If mul_en remains high, combinational outputs still follow the inputs.
- Overflow wraps silently: 32-bit for short, 64-bit for long.

## Configuration
- ARM7TDMI_MUL_CYCLES_EN: when defined, adds output mul_cycles [2:0], combinational, 0 when mul_en=0. Value follows ARM7 early-termination rules on operand_b.
  - Base m=1 if b[31:8] is all-0 or all-1 (all-1 applies to signed/short only); m=2 for [31:16]; m=3 for [31:24]; else m=4. Unsigned long uses the all-0 test only.
  - Add 1 if L, and 1 if A.
- When undefined, the port and its logic are absent. Arithmetic is identical either way.

## Test plan
- MUL 5*7, set_flags=1 -> result_lo=35, result_hi=0, result_ready=1, zero=0, negative=0.
- MLA 3*4+acc_lo 2 -> result_lo=14.
- UMULL 0xFFFFFFFF*0xFFFFFFFF, acc=0 -> hi=0xFFFFFFFE, lo=0x00000001, N=1.
- SMULL -1*-1 -> hi=0, lo=1, N=0, Z=0. SMLAL -2*3 + {0,5} -> {0xFFFFFFFF,0xFFFFFFFF}, N=1.
- MUL 0*42, set_flags=1 -> lo=0, zero=1. Next cycle mul_en=0 -> lo=0, zero held 1, result_ready=0.
- Assert rst_n=0 after a nonzero result with mul_en=0 -> all outputs 0 immediately. With set_flags=0, flags remain at the prior held values.
